poly_horner_eval: RTL

- Parametrised successor to the fixed quadratic evaluator.
- Computes y = c[N]·x^N + … + c[1]·x + c[0] in signed Q(W-F).F fixed point, for any degree N and run-time coefficients.
- Uses Horner's rule with one shared multiply-shift-add step, one coefficient per cycle, under a level start/done handshake.
- Sits where the old fixed-function block sat; adds selectable saturation and a sticky overflow flag.

---
 rtl/poly_pkg.sv | 23 ++
 rtl/poly_horner_eval_mac_step.sv | 42 ++++
 rtl/poly_horner_eval.sv | 107 ++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
package poly_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MAX_W = 128;

  // Largest positive value of a w-bit signed number, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] smax_bits(input int unsigned w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Most negative value of a w-bit signed number (bit pattern 100..0).
  function automatic logic [MAX_W-1:0] smin_bits(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/poly_horner_eval_mac_step.sv
// One Horner step: r = ((acc * x) >>> F) + c, with overflow detect and
// optional clamp. Purely combinational.
module poly_mac_step
  import poly_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned F        = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic signed [W-1:0] acc,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] c,
  output logic signed [W-1:0] r,
  output logic                ovf
);

  localparam logic signed [W-1:0] SMAX = W'(smax_bits(W));
  localparam logic signed [W-1:0] SMIN = W'(smin_bits(W));

  logic signed [2*W-1:0] p;
  logic signed [2*W-1:0] s;
  logic signed [2*W:0]   t;
  logic                  s_fit;
  logic                  t_fit;

  // The sum is kept at full precision so a clamp can follow the sign of the
  // true value even when the scaled product alone already overflowed; its low
  // W bits equal the wrapped product plus c, so wrap mode is unaffected.
  always_comb begin
    p     = (2*W)'(acc) * (2*W)'(x);
    s     = p >>> F;
    t     = (2*W+1)'(s) + (2*W+1)'(c);
    s_fit = (s[2*W-1:W-1] == '0) || (s[2*W-1:W-1] == '1);
    t_fit = (t[2*W:W-1] == '0) || (t[2*W:W-1] == '1);
    ovf   = !(s_fit && t_fit);
    r     = t[W-1:0];
    if (SATURATE && ovf) begin
      r = t[2*W] ? SMIN : SMAX;
    end
  end

endmodule

// File: rtl/poly_horner_eval.sv
// Polynomial evaluator y = sum c[k]*x^k in signed fixed point, one Horner
// step per cycle under a level start / done handshake.
module poly_horner_eval
  import poly_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned F        = 8,
  parameter int unsigned DEGREE   = 2,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_func,
  input  logic [W-1:0]              x_in,
  input  logic [(DEGREE+1)*W-1:0]   coeff_in,
  output logic [W-1:0]              y_out,
  output logic                      busy,
  output logic                      func_done,
  output logic                      overflow
);

  localparam int unsigned KW = $clog2(DEGREE + 1);

  state_t                    state;
  logic [KW-1:0]             k;
  logic signed [W-1:0]       acc;
  logic signed [W-1:0]       x_q;
  logic [(DEGREE+1)*W-1:0]   coeff_q;
  logic signed [W-1:0]       c_sel;
  logic signed [W-1:0]       step_r;
  logic                      step_ovf;

  // Select the captured coefficient for the current step.
  always_comb begin
    c_sel = '0;
    for (int unsigned i = 0; i <= DEGREE; i++) begin
      if (k == KW'(i)) begin
        c_sel = coeff_q[i*W +: W];
      end
    end
  end

  poly_mac_step #(
    .W        (W),
    .F        (F),
    .SATURATE (SATURATE)
  ) u_step (
    .acc (acc),
    .x   (x_q),
    .c   (c_sel),
    .r   (step_r),
    .ovf (step_ovf)
  );

  // Control FSM with registered outputs; y_out only changes on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      x_q       <= '0;
      coeff_q   <= '0;
      y_out     <= '0;
      busy      <= 1'b0;
      func_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          func_done <= 1'b0;
          if (start_func) begin
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          x_q      <= x_in;
          coeff_q  <= coeff_in;
          acc      <= coeff_in[DEGREE*W +: W];
          k        <= KW'(DEGREE - 1);
          overflow <= 1'b0;
          state    <= MAC;
        end
        MAC: begin
          acc      <= step_r;
          overflow <= overflow | step_ovf;
          if (k == '0) begin
            y_out     <= step_r;
            func_done <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            k <= k - 1'b1;
          end
        end
        DONE: begin
          if (!start_func) begin
            func_done <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
